iru_rot_engine: RTL and testbench

IRU_ROT_ENGINE -- requirements
Module: iru_rot_engine

---
 rtl/iru_pkg.sv | 26 ++
 rtl/iru_raster_counter.sv | 35 +++
 rtl/iru_rot_engine.sv | 135 +++++++++++++
 tb/tb_iru_rot_engine.sv | 351 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iru_pkg.sv
// Shared constants, state encoding and address helper for the 20x20 window rotation engine.
package iru_pkg;

    localparam int IRU_DIM     = 20;
    localparam int IRU_NUM_PIX = 400;
    localparam int IRU_ADDR_W  = 9;
    localparam int IRU_ANGLE_W = 36;
    localparam int IRU_COORD_W = 5;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        ISSUE   = 3'd1,
        FETCH   = 3'd2,
        PRESENT = 3'd3,
        DONE    = 3'd4
    } iru_rot_state_t;

    // Row-major linear address of a pixel inside the window.
    function automatic logic [IRU_ADDR_W-1:0] iru_lin_addr(
        input logic [IRU_COORD_W-1:0] row,
        input logic [IRU_COORD_W-1:0] col
    );
        return IRU_ADDR_W'(row) * IRU_ADDR_W'(IRU_DIM) + IRU_ADDR_W'(col);
    endfunction

endpackage

// File: rtl/iru_raster_counter.sv
// Row-major raster position over the 20x20 window with a flag for the final pixel.
module iru_raster_counter
    import iru_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   advance,
    output logic [IRU_COORD_W-1:0] row,
    output logic [IRU_COORD_W-1:0] col,
    output logic                   last
);

    localparam logic [IRU_COORD_W-1:0] MAX_IDX = IRU_COORD_W'(IRU_DIM - 1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            row <= '0;
            col <= '0;
        end else if (clear) begin
            row <= '0;
            col <= '0;
        end else if (advance) begin
            if (col == MAX_IDX) begin
                col <= '0;
                row <= (row == MAX_IDX) ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

    assign last = (row == MAX_IDX) && (col == MAX_IDX);

endmodule

// File: rtl/iru_rot_engine.sv
// Rotated-window pixel fetcher: walks the destination raster, asks the rotation unit for a source
// coordinate, reads it (or substitutes FILL_VALUE) and streams it out. Optional macro IRU_ROT_OOB_STATS_EN.
module iru_rot_engine
    import iru_pkg::*;
#(
    parameter logic [7:0] FILL_VALUE = 8'h00
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [IRU_ANGLE_W-1:0] angle,
    output logic                   busy,
    output logic                   done,
    output logic [IRU_ANGLE_W-1:0] comp_angle,
    output logic [IRU_COORD_W-1:0] comp_row_d,
    output logic [IRU_COORD_W-1:0] comp_col_d,
    input  logic                   comp_valid,
    input  logic [IRU_COORD_W-1:0] comp_row_q,
    input  logic [IRU_COORD_W-1:0] comp_col_q,
    output logic                   src_rd_en,
    output logic [IRU_ADDR_W-1:0]  src_rd_addr,
    input  logic [7:0]             src_rd_data,
    output logic                   pix_valid,
    input  logic                   pix_ready,
    output logic [7:0]             pix_data,
    output logic [IRU_ADDR_W-1:0]  pix_addr
`ifdef IRU_ROT_OOB_STATS_EN
    ,
    output logic [IRU_ADDR_W-1:0]  oob_count
`endif
);

    iru_rot_state_t         state_reg;
    logic                   fill_reg;
    logic [IRU_COORD_W-1:0] row;
    logic [IRU_COORD_W-1:0] col;
    logic                   last;
    logic                   accept;
    logic                   handshake;
    logic                   cnt_advance;

    assign accept      = (state_reg == IDLE) && start;
    assign handshake   = (state_reg == PRESENT) && pix_valid && pix_ready;
    assign cnt_advance = handshake && !last;

    iru_raster_counter u_raster (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (accept),
        .advance (cnt_advance),
        .row     (row),
        .col     (col),
        .last    (last)
    );

    assign comp_row_d = row;
    assign comp_col_d = col;

    // The rotation unit answers combinationally, so the read must be issued in the same cycle.
    assign src_rd_en   = (state_reg == ISSUE) && comp_valid;
    assign src_rd_addr = src_rd_en ? iru_lin_addr(comp_row_q, comp_col_q) : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            fill_reg   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            comp_angle <= '0;
            pix_valid  <= 1'b0;
            pix_data   <= '0;
            pix_addr   <= '0;
        end else begin
            done <= 1'b0;
            case (state_reg)
                IDLE: begin
                    if (start) begin
                        comp_angle <= angle;
                        busy       <= 1'b1;
                        state_reg  <= ISSUE;
                    end
                end
                ISSUE: begin
                    fill_reg <= !comp_valid;
                    if (comp_valid) begin
                        state_reg <= FETCH;
                    end else begin
                        pix_data  <= FILL_VALUE;
                        pix_valid <= 1'b1;
                        pix_addr  <= iru_lin_addr(row, col);
                        state_reg <= PRESENT;
                    end
                end
                FETCH: begin
                    pix_data  <= src_rd_data;
                    pix_valid <= 1'b1;
                    pix_addr  <= iru_lin_addr(row, col);
                    state_reg <= PRESENT;
                end
                PRESENT: begin
                    if (pix_ready) begin
                        pix_valid <= 1'b0;
                        if (last) begin
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state_reg <= DONE;
                        end else begin
                            state_reg <= ISSUE;
                        end
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                end
                default: begin
                    state_reg <= IDLE;
                end
            endcase
        end
    end

`ifdef IRU_ROT_OOB_STATS_EN
    // Counts emitted fill pixels; holds after the window so software can read it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            oob_count <= '0;
        end else if (accept) begin
            oob_count <= '0;
        end else if (handshake && fill_reg) begin
            oob_count <= oob_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_iru_rot_engine.sv
// Self-checking bench for iru_rot_engine: stub rotation unit, source memory and a pixel scoreboard.
module tb_iru_rot_engine;
    import iru_pkg::*;

    localparam logic [7:0] FILL = 8'hA5;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [35:0] angle = '0;
    logic        busy, done;
    logic [35:0] comp_angle;
    logic [4:0]  comp_row_d, comp_col_d;
    logic        comp_valid;
    logic [4:0]  comp_row_q, comp_col_q;
    logic        src_rd_en;
    logic [8:0]  src_rd_addr;
    logic [7:0]  src_rd_data = '0;
    logic        pix_valid;
    logic        pix_ready = 1'b1;
    logic [7:0]  pix_data;
    logic [8:0]  pix_addr;
`ifdef IRU_ROT_OOB_STATS_EN
    logic [8:0]  oob_count;
`endif

    iru_rot_engine #(.FILL_VALUE(FILL)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .angle       (angle),
        .busy        (busy),
        .done        (done),
        .comp_angle  (comp_angle),
        .comp_row_d  (comp_row_d),
        .comp_col_d  (comp_col_d),
        .comp_valid  (comp_valid),
        .comp_row_q  (comp_row_q),
        .comp_col_q  (comp_col_q),
        .src_rd_en   (src_rd_en),
        .src_rd_addr (src_rd_addr),
        .src_rd_data (src_rd_data),
        .pix_valid   (pix_valid),
        .pix_ready   (pix_ready),
        .pix_data    (pix_data),
        .pix_addr    (pix_addr)
`ifdef IRU_ROT_OOB_STATS_EN
        ,
        .oob_count   (oob_count)
`endif
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Stub rotation unit: 0 identity, 1 all out-of-range, 2 point mirror, 3 random table
    int          map_mode = 0;
    logic [7:0]  mem [IRU_NUM_PIX];
    logic        rv  [IRU_NUM_PIX];
    logic [4:0]  rr  [IRU_NUM_PIX];
    logic [4:0]  rc  [IRU_NUM_PIX];

    always_comb begin
        comp_valid = 1'b0;
        comp_row_q = '0;
        comp_col_q = '0;
        case (map_mode)
            0: begin comp_valid = 1'b1; comp_row_q = comp_row_d; comp_col_q = comp_col_d; end
            2: begin comp_valid = 1'b1; comp_row_q = 5'd19 - comp_row_d; comp_col_q = 5'd19 - comp_col_d; end
            3: begin
                if (comp_row_d < 5'd20 && comp_col_d < 5'd20) begin
                    comp_valid = rv[int'(comp_row_d) * 20 + int'(comp_col_d)];
                    comp_row_q = rr[int'(comp_row_d) * 20 + int'(comp_col_d)];
                    comp_col_q = rc[int'(comp_row_d) * 20 + int'(comp_col_d)];
                end
            end
            default: ;
        endcase
    end

    always @(posedge clk) begin
        if (src_rd_en && src_rd_addr < 9'd400) src_rd_data <= mem[src_rd_addr];
    end

    // Expected pixel k of the window, straight from the mapping definition
    function automatic logic [7:0] exp_data(input int k);
        int r, c;
        r = k / 20;
        c = k % 20;
        case (map_mode)
            0: return mem[r * 20 + c];
            1: return FILL;
            2: return mem[(19 - r) * 20 + (19 - c)];
            default: return rv[k] ? mem[int'(rr[k]) * 20 + int'(rc[k])] : FILL;
        endcase
    endfunction

    // Ready driver: 0 always, 1 toggle, 2 random, 3 hold low 50 cycles at the last pixel
    int ready_mode = 0;
    int hold_cnt = 0;
    always @(posedge clk) begin
        #1;
        case (ready_mode)
            1: pix_ready = ~pix_ready;
            2: pix_ready = 1'($urandom_range(0, 1));
            3: begin
                if (pix_valid && pix_addr == 9'd399 && hold_cnt < 50) begin
                    pix_ready = 1'b0;
                    hold_cnt++;
                end else begin
                    pix_ready = 1'b1;
                end
            end
            default: pix_ready = 1'b1;
        endcase
    end

    // Monitor: scoreboard capture plus stability and angle checks
    logic [8:0]  got_addr [$];
    logic [7:0]  got_data [$];
    int          rd_cnt = 0, done_cnt = 0, done_cyc = 0, last_hs_cyc = 0;
    int          first_valid_cyc = -1, start_cyc = 0;
    logic        hold_prev = 1'b0;
    logic [8:0]  hold_addr = '0;
    logic [7:0]  hold_data = '0;
    logic [35:0] exp_angle = '0;

    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (src_rd_en) rd_cnt++;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                chk("busy_during_done", 64'(busy), 64'd0);
            end
            if (pix_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
            if (hold_prev) begin
                chk("stable_valid", 64'(pix_valid), 64'd1);
                chk("stable_addr", 64'(pix_addr), 64'(hold_addr));
                chk("stable_data", 64'(pix_data), 64'(hold_data));
            end
            if (busy) chk("angle_const", 64'(comp_angle), 64'(exp_angle));
            if (pix_valid && pix_ready) begin
                got_addr.push_back(pix_addr);
                got_data.push_back(pix_data);
                last_hs_cyc = cyc;
            end
            hold_prev = pix_valid && !pix_ready;
            hold_addr = pix_addr;
            hold_data = pix_data;
        end
    end

    task automatic start_window(input logic [35:0] a);
        @(posedge clk);
        #1;
        got_addr.delete();
        got_data.delete();
        rd_cnt = 0;
        done_cnt = 0;
        first_valid_cyc = -1;
        exp_angle = a;
        angle = a;
        start = 1'b1;
        start_cyc = cyc;
        @(posedge clk);
        #1;
        start = 1'b0;
        angle = {4'($urandom), $urandom};
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_pixels(input int n, input int budget);
        int w = 0;
        while (got_addr.size() < n && w < budget) begin
            @(posedge clk);
            w++;
        end
        chk("wait_pixels_timeout", 64'(got_addr.size() >= n), 64'd1);
    endtask

    task automatic wait_done(input int budget);
        int w = 0;
        while (done_cnt == 0 && w < budget) begin
            @(posedge clk);
            w++;
        end
        chk("done_timeout", 64'(done_cnt > 0), 64'd1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_window(input string tag);
        int n;
        n = got_addr.size();
        chk($sformatf("%s_count", tag), 64'(n), 64'd400);
        if (n > 400) n = 400;
        for (int k = 0; k < n; k++) begin
            chk($sformatf("%s_addr[%0d]", tag, k), 64'(got_addr[k]), 64'(k));
            chk($sformatf("%s_data[%0d]", tag, k), 64'(got_data[k]), 64'(exp_data(k)));
        end
        chk($sformatf("%s_done_once", tag), 64'(done_cnt), 64'd1);
        chk($sformatf("%s_done_after_last", tag), 64'(done_cyc), 64'(last_hs_cyc + 1));
    endtask

    initial begin
        int n_valid;
        logic [35:0] a0;

        // Reset state
        #2 rst_n = 1'b0;
        #1;
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_pix_valid", 64'(pix_valid), 64'd0);
        chk("rst_src_rd_en", 64'(src_rd_en), 64'd0);
        chk("rst_comp_angle", 64'(comp_angle), 64'd0);
        repeat (3) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("post_rst_busy", 64'(busy), 64'd0);

        // Identity mapping, memory holds its own address
        for (int i = 0; i < IRU_NUM_PIX; i++) mem[i] = 8'(i);
        map_mode = 0;
        ready_mode = 0;
        start_window(36'h1_2345_6789);
        wait_done(3000);
        check_window("ident");
        chk("ident_latency", 64'(first_valid_cyc - start_cyc), 64'd3);
        chk("ident_reads", 64'(rd_cnt), 64'd400);
        chk("ident_throughput", 64'(done_cyc - start_cyc), 64'd1201);

        // Every coordinate out of range
        for (int i = 0; i < IRU_NUM_PIX; i++) mem[i] = 8'($urandom);
        map_mode = 1;
        start_window({4'($urandom), $urandom});
        wait_done(3000);
        check_window("fill");
        chk("fill_latency", 64'(first_valid_cyc - start_cyc), 64'd2);
        chk("fill_reads", 64'(rd_cnt), 64'd0);
        chk("fill_throughput", 64'(done_cyc - start_cyc), 64'd801);
`ifdef IRU_ROT_OOB_STATS_EN
        chk("fill_oob", 64'(oob_count), 64'd400);
`endif

        // Point mirror with toggling ready
        map_mode = 2;
        ready_mode = 1;
        start_window({4'($urandom), $urandom});
        wait_done(5000);
        check_window("mirror");
        if (got_data.size() > 5) begin
            chk("mirror_pix0", 64'(got_data[0]), 64'(mem[399]));
            chk("mirror_pix5", 64'(got_data[5]), 64'(mem[394]));
        end

        // Random mapping with random back-pressure
        n_valid = 0;
        for (int i = 0; i < IRU_NUM_PIX; i++) begin
            rv[i] = ($urandom_range(0, 3) != 0);
            rr[i] = 5'($urandom_range(0, 19));
            rc[i] = 5'($urandom_range(0, 19));
            if (rv[i]) n_valid++;
        end
        map_mode = 3;
        ready_mode = 2;
        start_window({4'($urandom), $urandom});
        wait_done(8000);
        check_window("random");
        chk("random_reads", 64'(rd_cnt), 64'(n_valid));
`ifdef IRU_ROT_OOB_STATS_EN
        chk("random_oob", 64'(oob_count), 64'(400 - n_valid));
`endif

        // start re-pulsed mid-window with another angle must be ignored
        map_mode = 0;
        ready_mode = 0;
        a0 = 36'hA_BCDE_F012;
        start_window(a0);
        wait_pixels(100, 2000);
        @(posedge clk);
        #1;
        start = 1'b1;
        angle = 36'h5_5555_5555;
        @(posedge clk);
        #1;
        start = 1'b0;
        wait_done(3000);
        check_window("repulse");
        chk("repulse_angle", 64'(comp_angle), 64'(a0));

        // Asynchronous reset mid-window
        start_window(36'h0_F0F0_F0F0);
        wait_pixels(200, 2000);
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        chk("arst_busy", 64'(busy), 64'd0);
        chk("arst_done", 64'(done), 64'd0);
        chk("arst_src_rd_en", 64'(src_rd_en), 64'd0);
        chk("arst_src_rd_addr", 64'(src_rd_addr), 64'd0);
        chk("arst_pix_valid", 64'(pix_valid), 64'd0);
        chk("arst_pix_data", 64'(pix_data), 64'd0);
        chk("arst_pix_addr", 64'(pix_addr), 64'd0);
        chk("arst_comp_angle", 64'(comp_angle), 64'd0);
        chk("arst_comp_row_d", 64'(comp_row_d), 64'd0);
        chk("arst_comp_col_d", 64'(comp_col_d), 64'd0);
`ifdef IRU_ROT_OOB_STATS_EN
        chk("arst_oob", 64'(oob_count), 64'd0);
`endif
        @(negedge clk) rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            chk("arst_idle_busy", 64'(busy), 64'd0);
            chk("arst_idle_valid", 64'(pix_valid), 64'd0);
        end
        start_window(36'h3_3333_3333);
        wait_done(3000);
        check_window("after_rst");

        // Back-pressure held on the final pixel
        ready_mode = 3;
        hold_cnt = 0;
        start_window(36'h7_0000_0001);
        wait_done(5000);
        check_window("hold_last");
        chk("hold_cycles", 64'(hold_cnt), 64'd50);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
